// File: rtl/read_operands_mi_pkg.sv
// rtl/read_operands_mi_pkg.sv - shared uop types and constants for the multi-issue read-operands stage
package read_operands_mi_pkg;

    localparam int ISSUE_WIDTH_MAX = 4;
    localparam int RO_XLEN         = 32;
    localparam int RO_NREG_BITS    = 5;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_LD, OP_ST, OP_BR, OP_JAL, OP_SYS
    } opcode_t;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0, EXC_ILLEGAL, EXC_IFETCH, EXC_ALIGN, EXC_ECALL
    } exception_t;

    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD, MEM_STORE} mem_type_t;
    typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H, MEM_W, MEM_D} mem_size_t;
    typedef enum logic [1:0] {SPEC_NONE = 2'd0, SPEC_FENCE, SPEC_CSR, SPEC_ERET} spec_opcode_t;

    typedef struct packed {
        logic [31:0]             pc;
        exception_t              exc;
        opcode_t                 opcode;
        logic [RO_NREG_BITS-1:0] src1;
        logic [RO_NREG_BITS-1:0] src2;
        logic                    src2_is_imm;
        logic [RO_XLEN-1:0]      imm;
        logic [RO_NREG_BITS-1:0] dest;
        logic                    is_branch;
        logic                    br_pred_taken;
        mem_type_t               mem_type;
        mem_size_t               mem_size;
        logic                    mem_signed;
        spec_opcode_t            spec_op;
    } ro_uop_t;

    function automatic logic uop_is_store(ro_uop_t u);
        return u.mem_type == MEM_STORE;
    endfunction

    function automatic logic uop_has_exc(ro_uop_t u);
        return u.exc != EXC_NONE;
    endfunction

endpackage

// File: rtl/read_operands_mi_lane_ready.sv
// rtl/read_operands_mi_lane_ready.sv - per-lane operand readiness and intra-group RAW hazard check
module ro_lane_ready
    import read_operands_mi_pkg::*;
(
    input  logic                                          i_lane_v,
    input  logic                                          i_ex_ok,
    input  logic [RO_NREG_BITS-1:0]                       i_src1,
    input  logic [RO_NREG_BITS-1:0]                       i_src2,
    input  logic                                          i_src2_is_imm,
    input  logic                                          i_is_store,
    input  logic                                          i_has_exc,
    input  logic [1:0]                                    i_rvalid,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    i_older_v,
    input  logic [ISSUE_WIDTH_MAX-1:0][RO_NREG_BITS-1:0]  i_older_dest,
    output logic                                          o_rdy
);

    logic w_use_src2;
    logic w_src1_ok;
    logic w_src2_ok;
    logic w_haz;

    // Stores read src2 as store data even when the ALU operand is the immediate.
    assign w_use_src2 = !i_src2_is_imm || i_is_store;
    assign w_src1_ok  = (i_src1 == '0) || i_rvalid[0];
    assign w_src2_ok  = !w_use_src2 || (i_src2 == '0) || i_rvalid[1];

    // i_older_v is pre-masked by the top to older, still-held lanes only.
    always_comb begin
        w_haz = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
            if (i_older_v[k] && (i_older_dest[k] != '0) &&
                ((i_older_dest[k] == i_src1) || (w_use_src2 && (i_older_dest[k] == i_src2))))
                w_haz = 1'b1;
        end
    end

    assign o_rdy = i_lane_v && i_ex_ok && !w_haz && (i_has_exc || (w_src1_ok && w_src2_ok));

endmodule

// File: rtl/read_operands_mi.sv
// rtl/read_operands_mi.sv - multi-issue read-operands stage, in-order partial issue; RO_PERF_CNT_EN adds ro_stall_cycles
module read_operands_mi
    import read_operands_mi_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int XLEN        = RO_XLEN,
    parameter int NREG_BITS   = RO_NREG_BITS
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        flush,
    input  logic                                        id_valid,
    input  logic [ISSUE_WIDTH-1:0]                      id_lane_valid,
    input  ro_uop_t [ISSUE_WIDTH-1:0]                   id_uop,
    output logic                                        ro_allowin,
    output logic [ISSUE_WIDTH-1:0][1:0][NREG_BITS-1:0]  rf_raddr,
    input  logic [ISSUE_WIDTH-1:0][1:0]                 rf_rvalid,
    input  logic [ISSUE_WIDTH-1:0][1:0][XLEN-1:0]       rf_rdata,
    input  logic [ISSUE_WIDTH-1:0]                      ex_allowin,
    output logic [ISSUE_WIDTH-1:0]                      ro_issue,
    output ro_uop_t [ISSUE_WIDTH-1:0]                   ro_uop,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]            ro_src1,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]            ro_src2,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]            ro_st_data
`ifdef RO_PERF_CNT_EN
    ,
    output logic [31:0]                                 ro_stall_cycles
`endif
);

    logic [ISSUE_WIDTH-1:0]                                        r_lane_v;
    ro_uop_t [ISSUE_WIDTH-1:0]                                     r_uop;
    logic [ISSUE_WIDTH-1:0]                                        w_ex_ok;
    logic [ISSUE_WIDTH-1:0]                                        w_rdy;
    logic [ISSUE_WIDTH-1:0][ISSUE_WIDTH_MAX-1:0]                   w_older_v;
    logic [ISSUE_WIDTH-1:0][ISSUE_WIDTH_MAX-1:0][RO_NREG_BITS-1:0] w_older_dest;
    logic                                                          w_load;

    // A non-prefix ex_allowin is reduced to its longest prefix.
    always_comb begin
        logic v_pfx;
        v_pfx   = 1'b1;
        w_ex_ok = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            v_pfx      = v_pfx && ex_allowin[i];
            w_ex_ok[i] = v_pfx;
        end
    end

    always_comb begin
        w_older_v    = '0;
        w_older_dest = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (k < i) begin
                    w_older_v[i][k]    = r_lane_v[k];
                    w_older_dest[i][k] = r_uop[k].dest;
                end
            end
        end
    end

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        ro_lane_ready u_ready (
            .i_lane_v      (r_lane_v[g]),
            .i_ex_ok       (w_ex_ok[g]),
            .i_src1        (r_uop[g].src1),
            .i_src2        (r_uop[g].src2),
            .i_src2_is_imm (r_uop[g].src2_is_imm),
            .i_is_store    (uop_is_store(r_uop[g])),
            .i_has_exc     (uop_has_exc(r_uop[g])),
            .i_rvalid      (rf_rvalid[g]),
            .i_older_v     (w_older_v[g]),
            .i_older_dest  (w_older_dest[g]),
            .o_rdy         (w_rdy[g])
        );
    end

    // An empty or issuing older lane lets younger lanes through; a stuck one blocks them.
    always_comb begin
        logic v_pass;
        v_pass   = 1'b1;
        ro_issue = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ro_issue[i] = w_rdy[i] && v_pass;
            v_pass      = v_pass && (ro_issue[i] || !r_lane_v[i]);
        end
    end

    assign ro_allowin = ((r_lane_v & ~ro_issue) == '0);
    assign w_load     = ro_allowin && id_valid && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush)
            r_lane_v <= '0;
        else if (ro_allowin && id_valid)
            r_lane_v <= id_lane_valid;
        else
            r_lane_v <= r_lane_v & ~ro_issue;
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_uop <= id_uop;
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rf_raddr[i][0] = NREG_BITS'(r_uop[i].src1);
            rf_raddr[i][1] = NREG_BITS'(r_uop[i].src2);
            ro_src1[i]     = (r_uop[i].src1 == '0) ? '0 : rf_rdata[i][0];
            ro_st_data[i]  = (r_uop[i].src2 == '0) ? '0 : rf_rdata[i][1];
            ro_src2[i]     = r_uop[i].src2_is_imm ? XLEN'(r_uop[i].imm) : ro_st_data[i];
        end
    end

    assign ro_uop = r_uop;

`ifdef RO_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cycles <= '0;
        else if ((r_lane_v != '0) && (ro_issue == '0))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign ro_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_read_operands_mi.sv
// tb/tb_read_operands_mi.sv - self-checking bench for read_operands_mi (vector table, hand sequences, random vs model)
module tb_read_operands_mi;
    import read_operands_mi_pkg::*;

    localparam int W = 2;

    logic                       clk = 1'b0;
    logic                       reset, flush, id_valid;
    logic [W-1:0]               id_lane_valid;
    ro_uop_t [W-1:0]            id_uop;
    logic                       ro_allowin;
    logic [W-1:0][1:0][4:0]     rf_raddr;
    logic [W-1:0][1:0]          rf_rvalid;
    logic [W-1:0][1:0][31:0]    rf_rdata;
    logic [W-1:0]               ex_allowin;
    logic [W-1:0]               ro_issue;
    ro_uop_t [W-1:0]            ro_uop;
    logic [W-1:0][31:0]         ro_src1, ro_src2, ro_st_data;
`ifdef RO_PERF_CNT_EN
    logic [31:0]                ro_stall_cycles;
`endif

    read_operands_mi #(.ISSUE_WIDTH(W), .XLEN(32), .NREG_BITS(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_lane_valid(id_lane_valid), .id_uop(id_uop), .ro_allowin(ro_allowin),
        .rf_raddr(rf_raddr), .rf_rvalid(rf_rvalid), .rf_rdata(rf_rdata),
        .ex_allowin(ex_allowin), .ro_issue(ro_issue), .ro_uop(ro_uop),
        .ro_src1(ro_src1), .ro_src2(ro_src2), .ro_st_data(ro_st_data)
`ifdef RO_PERF_CNT_EN
        , .ro_stall_cycles(ro_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which lanes of the held group are still waiting.
    bit [W-1:0]       m_v = '0;
    ro_uop_t [W-1:0]  m_uop;
    int unsigned      m_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ro_uop_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                   input bit im, input logic [31:0] imm, input bit st, input bit ex);
        ro_uop_t u;
        u             = '0;
        u.opcode      = st ? OP_ST : OP_ADD;
        u.src1        = s1;
        u.src2        = s2;
        u.dest        = d;
        u.src2_is_imm = im;
        u.imm         = imm;
        u.mem_type    = st ? MEM_STORE : MEM_NONE;
        u.exc         = ex ? EXC_ILLEGAL : EXC_NONE;
        return u;
    endfunction

    function automatic ro_uop_t rand_uop();
        ro_uop_t u;
        u = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0));
        u.pc = $urandom;
        return u;
    endfunction

    // A lane may go if its EX slot and every older slot are free, no older held lane
    // writes a register it reads, and its operands are present (or it carries an exception).
    function automatic bit lane_ready(input int i);
        ro_uop_t u;
        bit      need2;
        u     = m_uop[i];
        need2 = !u.src2_is_imm || (u.mem_type == MEM_STORE);
        for (int j = 0; j <= i; j++)
            if (!ex_allowin[j]) return 1'b0;
        for (int k = 0; k < i; k++)
            if (m_v[k] && m_uop[k].dest != 0 &&
                (m_uop[k].dest == u.src1 || (need2 && m_uop[k].dest == u.src2)))
                return 1'b0;
        if (u.exc != EXC_NONE) return 1'b1;
        if (u.src1 != 0 && !rf_rvalid[i][0]) return 1'b0;
        if (need2 && u.src2 != 0 && !rf_rvalid[i][1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_check();
        logic [W-1:0] e_iss;
        logic         e_allow;
        bit           stop;
        logic [31:0]  e_st;
        e_iss = '0;
        stop  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!m_v[i]) continue;
            if (stop || !lane_ready(i)) stop = 1'b1;
            else e_iss[i] = 1'b1;
        end
        e_allow = 1'b1;
        for (int i = 0; i < W; i++)
            if (m_v[i] && !e_iss[i]) e_allow = 1'b0;
        chk("model_issue", ro_issue, e_iss);
        chk("model_allowin", ro_allowin, e_allow);
        for (int i = 0; i < W; i++) begin
            if (m_v[i]) begin
                chk("model_raddr", rf_raddr[i], {m_uop[i].src2, m_uop[i].src1});
            end
            if (e_iss[i]) begin
                e_st = (m_uop[i].src2 == 0) ? 32'd0 : rf_rdata[i][1];
                chk("model_src1", ro_src1[i], (m_uop[i].src1 == 0) ? 32'd0 : rf_rdata[i][0]);
                chk("model_src2", ro_src2[i], m_uop[i].src2_is_imm ? m_uop[i].imm : e_st);
                chk("model_st_data", ro_st_data[i], e_st);
            end
        end
`ifdef RO_PERF_CNT_EN
        chk("model_stall_cnt", ro_stall_cycles, m_stall);
`endif
        if (reset) begin
            m_v     = '0;
            m_stall = 0;
        end else begin
            if (m_v != 0 && e_iss == 0) m_stall++;
            if (flush) m_v = '0;
            else if (e_allow && id_valid) begin
                m_v   = id_lane_valid;
                m_uop = id_uop;
            end else m_v = m_v & ~e_iss;
        end
    endtask

    // One clock: optional fixed-value check at the negedge, then the model, then advance.
    task automatic cyc(input bit tbl, input logic [1:0] ei, input logic ea, input string nm);
        @(negedge clk);
        if (tbl) begin
            chk({nm, "_issue"}, ro_issue, ei);
            chk({nm, "_allowin"}, ro_allowin, ea);
        end
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        flush    = 1'b1;
        id_valid = 1'b0;
        cyc(0, 2'b00, 1'b0, "");
        flush    = 1'b0;
    endtask

    task automatic load(input ro_uop_t u0, input ro_uop_t u1, input logic [1:0] lv);
        id_uop[0]     = u0;
        id_uop[1]     = u1;
        id_lane_valid = lv;
        id_valid      = 1'b1;
        cyc(0, 2'b00, 1'b0, "");
        id_valid      = 1'b0;
    endtask

    typedef struct {
        string      nm;
        ro_uop_t    u0;
        ro_uop_t    u1;
        logic [1:0] lv;
        logic [3:0] rv;
        logic [1:0] ex;
        logic [1:0] ei;
        logic       ea;
    } vec_t;

    vec_t vq[$];

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_lane_valid = '0;
        id_uop = '0; rf_rvalid = '0; ex_allowin = '0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < 2; j++) rf_rdata[i][j] = $urandom;

        @(posedge clk);
        #1;
        cyc(1, 2'b00, 1'b1, "reset");
        reset = 1'b0;

        vq.push_back('{"add_sub",   mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11, 4'b1111, 2'b11, 2'b11, 1'b1});
        vq.push_back('{"raw_src1",  mk(1,2,3,0,0,0,0), mk(3,4,5,0,0,0,0), 2'b11, 4'b1111, 2'b11, 2'b01, 1'b0});
        vq.push_back('{"l0_wait",   mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11, 4'b1110, 2'b11, 2'b00, 1'b0});
        vq.push_back('{"ex_01",     mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11, 4'b1111, 2'b01, 2'b01, 1'b0});
        vq.push_back('{"ex_10",     mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11, 4'b1111, 2'b10, 2'b00, 1'b0});
        vq.push_back('{"exc_imm",   mk(1,2,9,1,32'h7ff,0,1), mk(0,2,4,1,32'h7ff,0,0), 2'b11, 4'b0000, 2'b11, 2'b11, 1'b1});
        vq.push_back('{"l0_empty",  mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b10, 4'b1111, 2'b11, 2'b10, 1'b1});
        vq.push_back('{"st_imm",    mk(1,7,0,1,32'h10,1,0), mk(4,6,5,0,0,0,0), 2'b11, 4'b1101, 2'b11, 2'b00, 1'b0});
        vq.push_back('{"r0_srcs",   mk(0,0,1,0,0,0,0), mk(0,0,2,0,0,0,0), 2'b11, 4'b0000, 2'b11, 2'b11, 1'b1});
        vq.push_back('{"imm_nohaz", mk(1,3,2,0,0,0,0), mk(4,2,6,1,32'h5,0,0), 2'b11, 4'b1111, 2'b11, 2'b11, 1'b1});
        vq.push_back('{"l1_empty",  mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b01, 4'b1110, 2'b11, 2'b00, 1'b0});
        vq.push_back('{"st_haz",    mk(1,3,2,0,0,0,0), mk(4,2,0,1,32'h8,1,0), 2'b11, 4'b1111, 2'b11, 2'b01, 1'b0});

        foreach (vq[n]) begin
            clear();
            rf_rvalid  = vq[n].rv;
            ex_allowin = vq[n].ex;
            load(vq[n].u0, vq[n].u1, vq[n].lv);
            cyc(1, vq[n].ei, vq[n].ea, vq[n].nm);
        end

        // RAW between lanes: lane 1 waits one cycle after lane 0 leaves.
        clear();
        rf_rvalid = 4'b1111; ex_allowin = 2'b11;
        load(mk(1,2,3,0,0,0,0), mk(3,4,5,0,0,0,0), 2'b11);
        cyc(1, 2'b01, 1'b0, "haz_c1");
        cyc(1, 2'b10, 1'b1, "haz_c2");

        // Lane 0 source missing for three cycles, then both go together.
        clear();
        rf_rvalid = 4'b1110;
        load(mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11);
        for (int c = 0; c < 3; c++) cyc(1, 2'b00, 1'b0, "stall");
        rf_rvalid = 4'b1111;
        cyc(1, 2'b11, 1'b1, "stall_end");

        // Partial EX space, then the rest.
        clear();
        ex_allowin = 2'b01;
        load(mk(1,2,3,0,0,0,0), mk(4,6,5,0,0,0,0), 2'b11);
        cyc(1, 2'b01, 1'b0, "part_c1");
        ex_allowin = 2'b11;
        cyc(1, 2'b10, 1'b1, "part_c2");

        // Flush beats a simultaneous load.
        clear();
        flush = 1'b1; id_valid = 1'b1; id_lane_valid = 2'b11;
        id_uop[0] = mk(1,2,3,0,0,0,0); id_uop[1] = mk(4,6,5,0,0,0,0);
        cyc(1, 2'b00, 1'b1, "flush_ld");
        flush = 1'b0; id_valid = 1'b0;
        cyc(1, 2'b00, 1'b1, "flush_after");

        // Exception lane issues without operands; immediate reaches ro_src2.
        clear();
        rf_rvalid = 4'b0000;
        load(mk(1,2,9,1,32'h7ff,0,1), mk(0,2,4,1,32'h7ff,0,0), 2'b11);
        @(negedge clk);
        chk("exc_issue", ro_issue, 2'b11);
        chk("imm_src2", ro_src2[1], 32'h7ff);
        model_check();
        @(posedge clk);
        #1;

        for (int c = 0; c < 2000; c++) begin
            flush         = ($urandom_range(0, 31) == 0);
            id_valid      = bit'($urandom_range(0, 1));
            id_lane_valid = 2'($urandom_range(0, 3));
            id_uop[0]     = rand_uop();
            id_uop[1]     = rand_uop();
            ex_allowin    = 2'($urandom_range(0, 3));
            for (int i = 0; i < W; i++)
                for (int j = 0; j < 2; j++) begin
                    rf_rvalid[i][j] = ($urandom_range(0, 3) != 0);
                    rf_rdata[i][j]  = $urandom;
                end
            cyc(0, 2'b00, 1'b0, "");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
